// File: rtl/mem_alloc_pkg.sv
// Shared configuration for the memory allocator: widths, IO window marker, FSM encodings
// and a small byte-lane helper.
package mem_alloc_pkg;

   localparam int unsigned WordWidth      = 32;
   localparam int unsigned AddrWidth      = 32;
   localparam int unsigned WordBytesWidth = 2;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;
   localparam logic [WordWidth-1:0] ZERO = '0;

   // addr[17:16] value that selects the memory-mapped IO region
   localparam logic [1:0] IoHi = 2'b11;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;

   typedef enum logic {
      SrcIf  = 1'b0,
      SrcLsb = 1'b1
   } src_e;

   function automatic logic [7:0] byte_sel(input logic [WordWidth-1:0] w,
                                           input logic [WordBytesWidth-1:0] idx);
      return w[8*idx +: 8];
   endfunction

endpackage

// File: rtl/mem_alloc_if.sv
// Requester handshakes (fetch, LSB read, LSB write) and the byte-wide RAM/IO bus.
interface mem_alloc_if
   import mem_alloc_pkg::*;
#(
   parameter int unsigned ADDR_W = AddrWidth,
   parameter int unsigned WORD_W = WordWidth
) ();

   logic              io_buffer_full_in;

   logic              if_to_alloc_r_en_in;
   logic [ADDR_W-1:0] if_r_a_in;
   logic              alloc_to_if_gr_out;
   logic              alloc_to_if_en_out;
   logic [WORD_W-1:0] if_d_out;

   logic              lsb_to_alloc_r_en_in;
   logic [1:0]        lsb_r_offset_in;
   logic [ADDR_W-1:0] lsb_r_a_in;
   logic              alloc_to_lsb_r_gr_out;
   logic              alloc_to_lsb_r_en_out;
   logic [WORD_W-1:0] lsb_d_out;

   logic              lsb_to_alloc_w_en_in;
   logic [1:0]        lsb_w_offset_in;
   logic [ADDR_W-1:0] lsb_w_a_in;
   logic [WORD_W-1:0] lsb_d_in;
   logic              alloc_to_lsb_w_gr_out;
   logic              alloc_to_lsb_w_en_out;

   logic [7:0]        mem_din_in;
   logic [7:0]        mem_dout_out;
   logic [ADDR_W-1:0] mem_a_out;
   logic              mem_wr_out;

   // Allocator side
   modport slave (
      input  io_buffer_full_in,
      input  if_to_alloc_r_en_in, if_r_a_in,
      output alloc_to_if_gr_out, alloc_to_if_en_out, if_d_out,
      input  lsb_to_alloc_r_en_in, lsb_r_offset_in, lsb_r_a_in,
      output alloc_to_lsb_r_gr_out, alloc_to_lsb_r_en_out, lsb_d_out,
      input  lsb_to_alloc_w_en_in, lsb_w_offset_in, lsb_w_a_in, lsb_d_in,
      output alloc_to_lsb_w_gr_out, alloc_to_lsb_w_en_out,
      input  mem_din_in,
      output mem_dout_out, mem_a_out, mem_wr_out
   );

   // Requester / RAM environment side
   modport master (
      output io_buffer_full_in,
      output if_to_alloc_r_en_in, if_r_a_in,
      input  alloc_to_if_gr_out, alloc_to_if_en_out, if_d_out,
      output lsb_to_alloc_r_en_in, lsb_r_offset_in, lsb_r_a_in,
      input  alloc_to_lsb_r_gr_out, alloc_to_lsb_r_en_out, lsb_d_out,
      output lsb_to_alloc_w_en_in, lsb_w_offset_in, lsb_w_a_in, lsb_d_in,
      input  alloc_to_lsb_w_gr_out, alloc_to_lsb_w_en_out,
      output mem_din_in,
      input  mem_dout_out, mem_a_out, mem_wr_out
   );

endinterface

// File: rtl/mem_alloc.sv
// Memory allocator: arbitrates fetch / LSB read / LSB write and serializes each access
// byte by byte onto the RAM/IO bus, returning grant and done pulses.
module mem_alloc
   import mem_alloc_pkg::*;
#(
   parameter int unsigned ADDR_W = AddrWidth,
   parameter int unsigned WORD_W = WordWidth,
   parameter logic [1:0]  IO_HI  = IoHi
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         rdy_in,
   input  logic         clear_branch_in,
   mem_alloc_if.slave   bus
);

   logic [1:0]                state_q;
   logic [ADDR_W-1:0]         addr_q;
   logic [WordBytesWidth-1:0] offset_q;
   logic [WordBytesWidth-1:0] cnt_q;
   src_e                      src_q;
   logic [WORD_W-1:0]         wdata_q;
   logic [WORD_W-1:0]         rbuf_q;
   logic                      wr_done_q;

   logic              acc_w, acc_r, acc_f;
   logic [WORD_W-1:0] rd_word;
   logic              io_stall;
   logic [ADDR_W-1:0] byte_addr;
   logic [ADDR_W-1:0] next_addr;

   // Priority picker: a flush only blocks speculative (read) requests
   always_comb begin
      acc_w = bus.lsb_to_alloc_w_en_in;
      acc_r = !acc_w && bus.lsb_to_alloc_r_en_in && !clear_branch_in;
      acc_f = !acc_w && !bus.lsb_to_alloc_r_en_in && bus.if_to_alloc_r_en_in &&
              !clear_branch_in;
   end

   always_comb begin
      rd_word                 = rbuf_q;
      rd_word[8*cnt_q +: 8]   = bus.mem_din_in;
      io_stall  = (addr_q[17:16] == IO_HI) && bus.io_buffer_full_in;
      byte_addr = addr_q + ADDR_W'(cnt_q);
      next_addr = byte_addr + ADDR_W'(1);
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q                   <= IDLE;
         addr_q                    <= '0;
         offset_q                  <= '0;
         cnt_q                     <= '0;
         src_q                     <= SrcIf;
         wdata_q                   <= ZERO;
         rbuf_q                    <= ZERO;
         wr_done_q                 <= FALSE;
         bus.alloc_to_if_gr_out    <= FALSE;
         bus.alloc_to_if_en_out    <= FALSE;
         bus.if_d_out              <= ZERO;
         bus.alloc_to_lsb_r_gr_out <= FALSE;
         bus.alloc_to_lsb_r_en_out <= FALSE;
         bus.lsb_d_out             <= ZERO;
         bus.alloc_to_lsb_w_gr_out <= FALSE;
         bus.alloc_to_lsb_w_en_out <= FALSE;
         bus.mem_dout_out          <= '0;
         bus.mem_a_out             <= '0;
         bus.mem_wr_out            <= FALSE;
      end else if (rdy_in) begin
         bus.alloc_to_if_gr_out    <= FALSE;
         bus.alloc_to_if_en_out    <= FALSE;
         bus.alloc_to_lsb_r_gr_out <= FALSE;
         bus.alloc_to_lsb_r_en_out <= FALSE;
         bus.alloc_to_lsb_w_gr_out <= FALSE;
         bus.alloc_to_lsb_w_en_out <= FALSE;
         bus.mem_wr_out            <= FALSE;
         case (state_q)
            IDLE: begin
               bus.mem_a_out <= '0;
               cnt_q         <= '0;
               rbuf_q        <= ZERO;
               wr_done_q     <= FALSE;
               if (acc_w) begin
                  bus.alloc_to_lsb_w_gr_out <= TRUE;
                  state_q  <= WRITE;
                  src_q    <= SrcLsb;
                  addr_q   <= bus.lsb_w_a_in;
                  offset_q <= bus.lsb_w_offset_in;
                  wdata_q  <= bus.lsb_d_in;
               end else if (acc_r) begin
                  bus.alloc_to_lsb_r_gr_out <= TRUE;
                  state_q       <= READ;
                  src_q         <= SrcLsb;
                  addr_q        <= bus.lsb_r_a_in;
                  offset_q      <= bus.lsb_r_offset_in;
                  bus.mem_a_out <= bus.lsb_r_a_in;
               end else if (acc_f) begin
                  bus.alloc_to_if_gr_out <= TRUE;
                  state_q       <= READ;
                  src_q         <= SrcIf;
                  addr_q        <= bus.if_r_a_in;
                  offset_q      <= 2'd3;
                  bus.mem_a_out <= bus.if_r_a_in;
               end
            end

            READ: begin
               if (clear_branch_in) begin
                  state_q       <= IDLE;
                  bus.mem_a_out <= '0;
               end else begin
                  rbuf_q <= rd_word;
                  if (cnt_q == offset_q) begin
                     if (src_q == SrcIf) begin
                        bus.alloc_to_if_en_out <= TRUE;
                        bus.if_d_out           <= rd_word;
                     end else begin
                        bus.alloc_to_lsb_r_en_out <= TRUE;
                        bus.lsb_d_out             <= rd_word;
                     end
                     state_q       <= IDLE;
                     bus.mem_a_out <= '0;
                  end else begin
                     cnt_q         <= cnt_q + 2'd1;
                     bus.mem_a_out <= next_addr;
                  end
               end
            end

            WRITE: begin
               if (wr_done_q) begin
                  bus.alloc_to_lsb_w_en_out <= TRUE;
                  state_q          <= IDLE;
                  bus.mem_a_out    <= '0;
                  bus.mem_dout_out <= '0;
               end else begin
                  bus.mem_a_out <= byte_addr;
                  // A full IO sink holds cnt so the same byte is retried
                  if (!io_stall) begin
                     bus.mem_dout_out <= byte_sel(wdata_q, cnt_q);
                     bus.mem_wr_out   <= TRUE;
                     if (cnt_q == offset_q) begin
                        wr_done_q <= TRUE;
                     end else begin
                        cnt_q <= cnt_q + 2'd1;
                     end
                  end
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_alloc.sv
// Self-checking bench for mem_alloc: directed scenarios then random accesses checked
// against a byte-array memory model.
module tb_mem_alloc;
   import mem_alloc_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rdy   = 1'b1;
   logic clear = 1'b0;

   int passed = 0;
   int total  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   mem_alloc_if bus ();

   mem_alloc dut (
      .clk_in          (clk),
      .rst_in          (rst_n),
      .rdy_in          (rdy),
      .clear_branch_in (clear),
      .bus             (bus)
   );

   // Physical RAM seen by the DUT, and the bench's own idea of what memory should hold
   logic [7:0] ram   [4096];
   logic [7:0] model [4096];

   assign bus.mem_din_in = ram[bus.mem_a_out[11:0]];

   always @(posedge clk) begin
      if (bus.mem_wr_out) ram[bus.mem_a_out[11:0]] = bus.mem_dout_out;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preset(input logic [31:0] a, input logic [7:0] b);
      ram[a[11:0]]   = b;
      model[a[11:0]] = b;
   endtask

   task automatic do_read(input bit is_if, input logic [31:0] a, input logic [1:0] off,
                          input int hold_clear, input int flush_at, input string tag);
      logic [31:0] exp, ia, got;
      logic [31:0] addrs[$];
      int          waitc, lat;
      bit          got_gr, en_seen, wr_seen;
      exp = '0;
      for (int i = 0; i <= int'(off); i++) begin
         ia = a + i;
         exp[8*i +: 8] = model[ia[11:0]];
      end
      if (is_if) begin
         bus.if_to_alloc_r_en_in = 1'b1;
         bus.if_r_a_in           = a;
      end else begin
         bus.lsb_to_alloc_r_en_in = 1'b1;
         bus.lsb_r_a_in           = a;
         bus.lsb_r_offset_in      = off;
      end
      clear  = (hold_clear > 0);
      waitc  = 0;
      got_gr = 1'b0;
      while (!got_gr && waitc < 20) begin
         tick();
         waitc++;
         if (waitc == hold_clear) clear = 1'b0;
         got_gr = is_if ? bus.alloc_to_if_gr_out : bus.alloc_to_lsb_r_gr_out;
      end
      clear = 1'b0;
      check({tag, ".gr_wait"}, waitc, hold_clear + 1);
      check({tag, ".gr_onehot"},
            {bus.alloc_to_if_gr_out, bus.alloc_to_lsb_r_gr_out, bus.alloc_to_lsb_w_gr_out},
            is_if ? 3'b100 : 3'b010);
      bus.if_to_alloc_r_en_in  = 1'b0;
      bus.lsb_to_alloc_r_en_in = 1'b0;
      addrs.push_back(bus.mem_a_out);
      wr_seen = bus.mem_wr_out;
      en_seen = 1'b0;
      lat     = 0;
      while (!en_seen && lat < 12) begin
         clear = (flush_at > 0) && (lat == flush_at);
         tick();
         lat++;
         wr_seen |= bus.mem_wr_out;
         en_seen = is_if ? bus.alloc_to_if_en_out : bus.alloc_to_lsb_r_en_out;
         if (!en_seen) addrs.push_back(bus.mem_a_out);
      end
      clear = 1'b0;
      if (flush_at > 0) begin
         check({tag, ".no_en"}, en_seen, 1'b0);
         check({tag, ".idle_addr"}, bus.mem_a_out, 32'h0);
      end else begin
         check({tag, ".latency"}, lat, off + 1);
         got = is_if ? bus.if_d_out : bus.lsb_d_out;
         check({tag, ".data"}, got, exp);
         for (int i = 0; i <= int'(off); i++) begin
            check($sformatf("%s.addr%0d", tag, i),
                  (i < addrs.size()) ? addrs[i] : 32'hxxxx_xxxx, a + i);
         end
      end
      check({tag, ".no_wr"}, wr_seen, 1'b0);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [1:0] off, input logic [31:0] d,
                           input int stall, input int flush_at, input string tag);
      logic [31:0] ia;
      logic [31:0] wa[$];
      logic [7:0]  wd[$];
      int          waitc, lat;
      bit          got_gr, en_seen;
      bus.lsb_to_alloc_w_en_in = 1'b1;
      bus.lsb_w_a_in           = a;
      bus.lsb_w_offset_in      = off;
      bus.lsb_d_in             = d;
      clear  = (flush_at == 0);
      waitc  = 0;
      got_gr = 1'b0;
      while (!got_gr && waitc < 20) begin
         tick();
         waitc++;
         got_gr = bus.alloc_to_lsb_w_gr_out;
      end
      clear = 1'b0;
      check({tag, ".gr_wait"}, waitc, 1);
      check({tag, ".gr_onehot"},
            {bus.alloc_to_if_gr_out, bus.alloc_to_lsb_r_gr_out, bus.alloc_to_lsb_w_gr_out},
            3'b001);
      bus.lsb_to_alloc_w_en_in = 1'b0;
      bus.io_buffer_full_in    = (stall > 0);
      for (int i = 0; i <= int'(off); i++) begin
         ia = a + i;
         model[ia[11:0]] = d[8*i +: 8];
      end
      en_seen = 1'b0;
      lat     = 0;
      while (!en_seen && lat < 16) begin
         clear = (flush_at > 0) && (lat == flush_at);
         tick();
         lat++;
         if (lat == stall) bus.io_buffer_full_in = 1'b0;
         en_seen = bus.alloc_to_lsb_w_en_out;
         if (bus.mem_wr_out) begin
            wa.push_back(bus.mem_a_out);
            wd.push_back(bus.mem_dout_out);
         end
      end
      clear = 1'b0;
      bus.io_buffer_full_in = 1'b0;
      check({tag, ".latency"}, lat, off + 2 + stall);
      check({tag, ".nbytes"}, wa.size(), off + 1);
      for (int i = 0; i <= int'(off); i++) begin
         check($sformatf("%s.waddr%0d", tag, i),
               (i < wa.size()) ? wa[i] : 32'hxxxx_xxxx, a + i);
         check($sformatf("%s.wdata%0d", tag, i),
               (i < wd.size()) ? {24'h0, wd[i]} : 32'hxxxx_xxxx, {24'h0, d[8*i +: 8]});
      end
   endtask

   initial begin
      logic [31:0] ra, rd;
      logic [1:0]  roff;
      int          op, waitc, fl;
      bit          got_gr, en_seen, wr_seen;

      bus.io_buffer_full_in    = 1'b0;
      bus.if_to_alloc_r_en_in  = 1'b0;
      bus.if_r_a_in            = '0;
      bus.lsb_to_alloc_r_en_in = 1'b0;
      bus.lsb_r_offset_in      = '0;
      bus.lsb_r_a_in           = '0;
      bus.lsb_to_alloc_w_en_in = 1'b0;
      bus.lsb_w_offset_in      = '0;
      bus.lsb_w_a_in           = '0;
      bus.lsb_d_in             = '0;
      for (int i = 0; i < 4096; i++) begin
         rd = $urandom;
         ram[i]   = rd[7:0];
         model[i] = rd[7:0];
      end

      tick();
      tick();
      check("rst.mem_a", bus.mem_a_out, 32'h0);
      check("rst.mem_wr", bus.mem_wr_out, 1'b0);
      check("rst.mem_dout", bus.mem_dout_out, 8'h0);
      check("rst.pulses",
            {bus.alloc_to_if_gr_out, bus.alloc_to_if_en_out, bus.alloc_to_lsb_r_gr_out,
             bus.alloc_to_lsb_r_en_out, bus.alloc_to_lsb_w_gr_out, bus.alloc_to_lsb_w_en_out},
            6'b0);
      check("rst.if_d", bus.if_d_out, 32'h0);
      check("rst.lsb_d", bus.lsb_d_out, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Fetch of an encoded instruction
      preset(32'h100, 8'h13);
      preset(32'h101, 8'h05);
      preset(32'h102, 8'h10);
      preset(32'h103, 8'h00);
      do_read(1'b1, 32'h100, 2'd3, 0, 0, "fetch");
      check("fetch.word", bus.if_d_out, 32'h0010_0513);

      // LB
      preset(32'h2001, 8'hF0);
      do_read(1'b0, 32'h2001, 2'd0, 0, 0, "lb");
      check("lb.word", bus.lsb_d_out, 32'h0000_00F0);

      // SW contending with a fetch of the same word
      bus.if_to_alloc_r_en_in = 1'b1;
      bus.if_r_a_in           = 32'h40;
      do_write(32'h40, 2'd3, 32'hDEAD_BEEF, 0, -1, "sw");
      do_read(1'b1, 32'h40, 2'd3, 0, 0, "sw_fetch");
      check("sw_fetch.word", bus.if_d_out, 32'hDEAD_BEEF);

      // SB into the IO window with the sink full for three cycles
      do_write(32'h3_0000, 2'd0, 32'h0000_0041, 3, -1, "io_sb");

      // Flush aborts a LW, then the same LW completes
      do_read(1'b0, 32'h200, 2'd3, 0, 2, "lw_flush");
      do_read(1'b0, 32'h200, 2'd3, 0, 0, "lw_after");

      // Flush held in IDLE delays a fetch but not a write
      do_read(1'b1, 32'h300, 2'd3, 2, 0, "fetch_blk");
      do_write(32'h80, 2'd1, 32'h1234_ABCD, 0, 0, "sh_idleclr");
      do_write(32'h90, 2'd1, 32'h0000_5A6B, 0, 1, "sh_flush");
      do_read(1'b0, 32'h90, 2'd1, 0, 0, "lh_check");

      // Random traffic against the memory model
      for (int n = 0; n < 40; n++) begin
         op = int'($urandom_range(0, 6));
         ra = $urandom;
         rd = $urandom;
         case ($urandom_range(0, 2))
            0:       roff = 2'd0;
            1:       roff = 2'd1;
            default: roff = 2'd3;
         endcase
         if (op == 0) begin
            do_read(1'b1, ra, 2'd3, int'($urandom_range(0, 2)), 0, $sformatf("r%0d.if", n));
         end else if (op <= 3) begin
            do_read(1'b0, ra, roff, int'($urandom_range(0, 1)), 0, $sformatf("r%0d.ld", n));
         end else begin
            fl = int'($urandom_range(0, 3)) - 1;
            do_write(ra, roff, rd, 0, fl, $sformatf("r%0d.st", n));
         end
      end

      // Asynchronous reset in the middle of a SW
      bus.lsb_to_alloc_w_en_in = 1'b1;
      bus.lsb_w_a_in           = 32'h500;
      bus.lsb_w_offset_in      = 2'd3;
      bus.lsb_d_in             = 32'hCAFE_F00D;
      waitc  = 0;
      got_gr = 1'b0;
      while (!got_gr && waitc < 20) begin
         tick();
         waitc++;
         got_gr = bus.alloc_to_lsb_w_gr_out;
      end
      check("rstw.gr", got_gr, 1'b1);
      bus.lsb_to_alloc_w_en_in = 1'b0;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("rstw.mem_wr", bus.mem_wr_out, 1'b0);
      check("rstw.mem_a", bus.mem_a_out, 32'h0);
      check("rstw.mem_dout", bus.mem_dout_out, 8'h0);
      @(negedge clk);
      rst_n   = 1'b1;
      en_seen = 1'b0;
      wr_seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         en_seen |= bus.alloc_to_lsb_w_en_out;
         wr_seen |= bus.mem_wr_out;
      end
      check("rstw.no_en", en_seen, 1'b0);
      check("rstw.no_wr", wr_seen, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
